// File: rtl/pcm_frame_buffer_pkg.sv
// Shared definitions for the PCM frame buffer: register map, status word layout,
// FSM state encodings and the stereo frame type stored in the FIFO.
package pcm_frame_buffer_pkg;

  localparam logic REG_STATUS = 1'b0;
  localparam logic REG_VOLUME = 1'b1;

  localparam int STAT_LEVEL_LSB = 0;
  localparam int STAT_MUTE_BIT  = 8;
  localparam int STAT_STATE_BIT = 9;
  localparam int STAT_UNF_LSB   = 16;
  localparam int STAT_OVF_LSB   = 24;

  localparam int CTRL_CLR_BIT  = 0;
  localparam int CTRL_MUTE_BIT = 1;

  typedef enum logic {
    ST_FILLING = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } frame_t;

endpackage

// File: rtl/pcm_sync_fifo.sv
// Policy-free synchronous FIFO: write on push, advance on pop, level tracks occupancy.
// Read data is combinational from the head entry; caller must never push when full without popping.
module pcm_sync_fifo #(
  parameter int DEPTH_LOG2 = 5,
  parameter int WIDTH      = 32
) (
  input  logic                  clk_24m,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_dat,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_dat,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  always_ff @(posedge clk_24m) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Head read happens before a same-cycle write, so a full push+pop returns the oldest frame.
  assign pop_dat = mem[rd_ptr];
  assign full    = (level == DEPTH_LVL);
  assign empty   = (level == '0);

endmodule

// File: rtl/pcm_frame_buffer.sv
// Stereo rate-matching FIFO between the YM3016 decoder and S/PDIF tx, with Wishbone status/control.
// Optional attenuation shifter on reg 1 when PCM_FRAME_BUFFER_VOLUME_EN is defined.
module pcm_frame_buffer
  import pcm_frame_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5,
  parameter int PREFILL    = 16
) (
  input  logic        clk_24m,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_left,
  input  logic [15:0] in_right,
  input  logic        spdif_sel,
  output logic [23:0] spdif_data,
  input  logic        wb_addr,
  input  logic [31:0] wb_wdata,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic [31:0] wb_rdata,
  output logic        wb_ack
);

  localparam logic [DEPTH_LOG2:0] PREFILL_LVL = PREFILL[DEPTH_LOG2:0];

  frame_t                push_frame;
  frame_t                pop_frame;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  sel_q;
  logic                  strobe;
  logic                  do_pop;
  logic                  do_push;
  state_t                state;
  logic [15:0]           out_l;
  logic [15:0]           out_r;
  logic [7:0]            ovf_cnt;
  logic [7:0]            unf_cnt;
  logic                  mute;
  logic                  wb_acc;
  logic                  wb_wr_status;
  logic [31:0]           status_word;
  logic [31:0]           volume_word;
  logic [15:0]           sel_sample;
  logic [15:0]           shaped;
  logic                  unused_wdata;

  assign push_frame = '{left: in_left, right: in_right};

  pcm_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (32)
  ) u_fifo (
    .clk_24m  (clk_24m),
    .rst      (rst),
    .push     (do_push),
    .push_dat (push_frame),
    .pop      (do_pop),
    .pop_dat  (pop_frame),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  // One pop strobe per S/PDIF frame, on the right-to-left subframe transition.
  assign strobe  = sel_q & ~spdif_sel;
  assign do_pop  = strobe && (state == ST_RUNNING) && !fifo_empty;
  assign do_push = in_valid && (!fifo_full || do_pop);

  assign wb_acc       = wb_cyc && !wb_ack;
  assign wb_wr_status = wb_acc && wb_we && (wb_addr == REG_STATUS);
  assign unused_wdata = ^wb_wdata[31:2];

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      state   <= ST_FILLING;
      sel_q   <= 1'b0;
      out_l   <= '0;
      out_r   <= '0;
      ovf_cnt <= '0;
      unf_cnt <= '0;
      mute    <= 1'b0;
    end else begin
      sel_q <= spdif_sel;
      if (in_valid && !do_push && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      case (state)
        ST_FILLING: begin
          if (level >= PREFILL_LVL) state <= ST_RUNNING;
        end
        ST_RUNNING: begin
          if (strobe) begin
            if (do_pop) begin
              out_l <= pop_frame.left;
              out_r <= pop_frame.right;
            end else begin
              if (unf_cnt != 8'hFF) unf_cnt <= unf_cnt + 8'd1;
              state <= ST_FILLING;
            end
          end
        end
        default: state <= ST_FILLING;
      endcase
      // Clear wins over any increment in the same cycle.
      if (wb_wr_status) begin
        if (wb_wdata[CTRL_CLR_BIT]) begin
          ovf_cnt <= '0;
          unf_cnt <= '0;
        end
        mute <= wb_wdata[CTRL_MUTE_BIT];
      end
    end
  end

  always_comb begin
    status_word                          = '0;
    status_word[STAT_OVF_LSB +: 8]       = ovf_cnt;
    status_word[STAT_UNF_LSB +: 8]       = unf_cnt;
    status_word[STAT_STATE_BIT]          = (state == ST_RUNNING);
    status_word[STAT_MUTE_BIT]           = mute;
    status_word[STAT_LEVEL_LSB +: 7]     = 7'(level);
  end

`ifdef PCM_FRAME_BUFFER_VOLUME_EN
  logic [3:0] att;
  assign volume_word = {28'h0, att};
`else
  assign volume_word = 32'h0;
`endif

  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
`ifdef PCM_FRAME_BUFFER_VOLUME_EN
      att      <= '0;
`endif
    end else begin
      wb_ack   <= wb_acc;
      wb_rdata <= '0;
      if (wb_acc) begin
        case (wb_addr)
          REG_STATUS: wb_rdata <= status_word;
          REG_VOLUME: wb_rdata <= volume_word;
          default:    wb_rdata <= '0;
        endcase
      end
`ifdef PCM_FRAME_BUFFER_VOLUME_EN
      if (wb_acc && wb_we && wb_addr == REG_VOLUME) att <= wb_wdata[3:0];
`endif
    end
  end

  always_comb begin
    sel_sample = spdif_sel ? out_r : out_l;
`ifdef PCM_FRAME_BUFFER_VOLUME_EN
    shaped = $signed(sel_sample) >>> att;
`else
    shaped = sel_sample;
`endif
    spdif_data = mute ? 24'h0 : {shaped, 8'h00};
  end

endmodule

// File: tb/tb_pcm_frame_buffer.sv
// Directed bench for pcm_frame_buffer: Wishbone reads and S/PDIF probes are checked by a
// negedge monitor against expectations queued by the stimulus thread.
module tb_pcm_frame_buffer;

  logic        clk_24m;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic        spdif_sel;
  logic [23:0] spdif_data;
  logic        wb_addr;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdata;
  logic        wb_ack;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [31:0] sp_exp_q[$];
  string       sp_name_q[$];
  logic        sp_probe = 1'b0;

  pcm_frame_buffer dut (
    .clk_24m    (clk_24m),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_left    (in_left),
    .in_right   (in_right),
    .spdif_sel  (spdif_sel),
    .spdif_data (spdif_data),
    .wb_addr    (wb_addr),
    .wb_wdata   (wb_wdata),
    .wb_we      (wb_we),
    .wb_cyc     (wb_cyc),
    .wb_rdata   (wb_rdata),
    .wb_ack     (wb_ack)
  );

  initial clk_24m = 1'b0;
  always #10 clk_24m = ~clk_24m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stat(input logic [7:0] ovf, input logic [7:0] unf,
                                       input logic st, input logic m, input logic [6:0] lv);
    return {ovf, unf, 6'b0, st, m, 1'b0, lv};
  endfunction

  // Scoreboard monitor.
  always @(negedge clk_24m) begin
    if (wb_ack && !wb_we) begin
      if (rd_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got 0x%08h expected no ack", wb_rdata);
      end else begin
        check(rd_name_q.pop_front(), wb_rdata, rd_exp_q.pop_front());
      end
    end
    if (sp_probe) begin
      if (sp_exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sp_unexpected: got 0x%06h expected no probe", spdif_data);
      end else begin
        check(sp_name_q.pop_front(), {8'h0, spdif_data}, sp_exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_24m);
    #1;
  endtask

  task automatic wb_access(input logic addr, input logic we, input logic [31:0] wdata);
    int n;
    bit got;
    wb_addr  = addr;
    wb_we    = we;
    wb_wdata = wdata;
    wb_cyc   = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 4) begin
      tick();
      n++;
      if (wb_ack) got = 1'b1;
    end
    check("ack_latency", 32'(n), 32'd1);
    tick();
    wb_cyc = 1'b0;
    wb_we  = 1'b0;
    check("ack_width", {31'h0, wb_ack}, 32'h0);
    check("rdata_idle", wb_rdata, 32'h0);
  endtask

  task automatic wb_read(input logic addr, input logic [31:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    wb_access(addr, 1'b0, 32'h0);
  endtask

  task automatic wb_write(input logic addr, input logic [31:0] data);
    wb_access(addr, 1'b1, data);
  endtask

  task automatic expect_spdif(input logic [23:0] exp, input string name);
    sp_exp_q.push_back({8'h0, exp});
    sp_name_q.push_back(name);
    sp_probe = 1'b1;
    tick();
    sp_probe = 1'b0;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic strobe();
    spdif_sel = 1'b1;
    tick();
    spdif_sel = 1'b0;
    tick();
  endtask

  task automatic strobe_push(input logic [15:0] l, input logic [15:0] r);
    spdif_sel = 1'b1;
    tick();
    spdif_sel = 1'b0;
    in_left   = l;
    in_right  = r;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0; spdif_sel = 1'b0;
    wb_addr = 1'b0; wb_wdata = '0; wb_we = 1'b0; wb_cyc = 1'b0;
    repeat (2) tick();
    @(negedge clk_24m);
    check("reset_ack", {31'h0, wb_ack}, 32'h0);
    check("reset_rdata", wb_rdata, 32'h0);
    check("reset_spdif", {8'h0, spdif_data}, 32'h0);
    tick();
    rst = 1'b0;
    wb_read(1'b0, stat(8'd0, 8'd0, 1'b0, 1'b0, 7'd0), "reset_status");

    // Prefill to 16, then first pop.
    for (int i = 0; i < 16; i++) push(16'h1000 + 16'(i), 16'h2000 + 16'(i));
    wb_read(1'b0, stat(8'd0, 8'd0, 1'b0, 1'b0, 7'd16), "prefill_level16");
    strobe();
    wb_read(1'b0, stat(8'd0, 8'd0, 1'b1, 1'b0, 7'd15), "first_pop_status");
    expect_spdif(24'h100000, "first_pop_left");
    spdif_sel = 1'b1;
    expect_spdif(24'h200000, "first_pop_right");

    // Drain, then underrun.
    for (int i = 0; i < 15; i++) strobe();
    wb_read(1'b0, stat(8'd0, 8'd0, 1'b1, 1'b0, 7'd0), "drained_status");
    expect_spdif(24'h100F00, "last_frame");
    strobe();
    strobe();
    strobe();
    wb_read(1'b0, stat(8'd0, 8'd1, 1'b0, 1'b0, 7'd0), "underrun_status");
    expect_spdif(24'h100F00, "underrun_hold");

    // Fill to full, one dropped frame.
    for (int i = 0; i < 32; i++) push(16'h3000 + 16'(i), 16'h4000 + 16'(i));
    push(16'h5555, 16'h5555);
    wb_read(1'b0, stat(8'd1, 8'd1, 1'b1, 1'b0, 7'd32), "overflow_status");

    // Push and pop together at full.
    strobe_push(16'h6000, 16'h7000);
    wb_read(1'b0, stat(8'd1, 8'd1, 1'b1, 1'b0, 7'd32), "full_pushpop_status");
    expect_spdif(24'h300000, "full_pushpop_head");
    for (int i = 0; i < 32; i++) strobe();
    wb_read(1'b0, stat(8'd1, 8'd1, 1'b1, 1'b0, 7'd0), "tail_drain_status");
    expect_spdif(24'h600000, "tail_frame");

    // Clear counters and mute.
    wb_write(1'b0, 32'h3);
    wb_read(1'b0, stat(8'd0, 8'd0, 1'b1, 1'b1, 7'd0), "clear_mute_status");
    expect_spdif(24'h000000, "muted");
    wb_write(1'b0, 32'h0);
    expect_spdif(24'h600000, "unmuted");

`ifdef PCM_FRAME_BUFFER_VOLUME_EN
    wb_write(1'b1, 32'h4);
    wb_read(1'b1, 32'h4, "volume_readback");
    push(16'h8000, 16'h0001);
    strobe();
    expect_spdif(24'hF80000, "volume_shift");
    wb_write(1'b1, 32'h0);
    expect_spdif(24'h800000, "volume_off");
`else
    wb_write(1'b1, 32'hF);
    wb_read(1'b1, 32'h0, "volume_absent");
    expect_spdif(24'h600000, "volume_absent_spdif");
`endif

    // Reset mid-stream at level 10.
    for (int i = 0; i < 10; i++) push(16'h7100 + 16'(i), 16'h7180 + 16'(i));
    wb_read(1'b0, stat(8'd0, 8'd0, 1'b1, 1'b0, 7'd10), "level10_status");
    rst = 1'b1;
    @(negedge clk_24m);
    check("midrst_spdif", {8'h0, spdif_data}, 32'h0);
    check("midrst_ack", {31'h0, wb_ack}, 32'h0);
    check("midrst_rdata", wb_rdata, 32'h0);
    tick();
    rst = 1'b0;
    wb_read(1'b0, stat(8'd0, 8'd0, 1'b0, 1'b0, 7'd0), "post_reset_status");
    for (int i = 0; i < 15; i++) push(16'h7200 + 16'(i), 16'h7280 + 16'(i));
    strobe();
    expect_spdif(24'h000000, "no_pop_below_prefill");
    wb_read(1'b0, stat(8'd0, 8'd0, 1'b0, 1'b0, 7'd15), "level15_filling");
    push(16'h720F, 16'h728F);
    tick();
    strobe();
    expect_spdif(24'h720000, "pop_after_prefill");
    wb_read(1'b0, stat(8'd0, 8'd0, 1'b1, 1'b0, 7'd15), "resumed_status");

    repeat (3) tick();
    check("sb_drain", 32'(rd_exp_q.size() + sp_exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
